ysyx_24070014_mem_arbiter: RTL and testbench
============================================

Name: ysyx_24070014_mem_arbiter

Overview:
- Shares one memory port between two requesters: the instruction-fetch path (read-only) and the load/store path (read/write).
- Each requester uses a valid/ready request channel and a one-cycle response pulse; the memory side is a valid/ready request plus a variable-latency response.
- Holds one outstanding transaction at a time and routes the response back to the requester that issued it.
- A watchdog counter retires transactions the memory never answers.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width; byte mask width is DATA_W/8.
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before forced retirement; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_req_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  fetch response pulse
- ifu_resp_data  out  DATA_W  fetched word
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  load/store request accepted this cycle
- lsu_req_addr  in  ADDR_W  load/store address
- lsu_req_wen  in  1  1 = store
- lsu_req_wdata  in  DATA_W  store data
- lsu_req_wmask  in  DATA_W/8  store byte enables
- lsu_resp_valid  out  1  load/store response pulse; stores also get one
- lsu_resp_data  out  DATA_W  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  latched address
- mem_req_wen  out  1  latched write enable; 0 for fetch
- mem_req_wdata  out  DATA_W  latched store data
- mem_req_wmask  out  DATA_W/8  latched mask; 0 for fetch
- mem_resp_valid  in  1  memory response
- mem_resp_data  in  DATA_W  memory read data
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- Reset: state=IDLE. All *_valid, *_ready, busy and timeout_err are 0. Latched addr/wdata/wmask/wen, owner, response data and counter are 0.
- Reset mid-transaction drops the transaction; no response is ever issued for it.
- States: IDLE, REQ, WAIT, RESP.
- IDLE arbitration: fixed priority, LSU over IFU.
  - lsu_req_ready = lsu_req_valid.
  - ifu_req_ready = ifu_req_valid & ~lsu_req_valid.
  - Both ready outputs are combinational and are 0 in every state other than IDLE.
  - On acceptance (valid & ready): latch the request fields and owner, clear the counter, go to REQ.
  - For an IFU grant, latched wen=0 and wmask=0.
- REQ: mem_req_valid=1 with the latched fields, held stable until mem_req_ready. On mem_req_valid & mem_req_ready, go to WAIT.
- WAIT: on mem_resp_valid, capture mem_resp_data and go to RESP. mem_resp_valid seen in REQ or IDLE is ignored.
- RESP: assert the owner's resp_valid for exactly one cycle, with resp_data = captured data; then go to IDLE.
  - The non-owner's resp_valid stays 0.
  - Response data outputs are registered and hold their value until the next RESP.
  - ready is 0 in RESP; a new grant occurs no earlier than the following IDLE cycle.
- Latency with memory ready and response in the same cycle: accept at cycle 0; mem_req_valid at cycle 1; WAIT at cycle 2; memory response at cycle k≥2; resp_valid at cycle k+1. Minimum request-to-response is 3 cycles, and there is one idle cycle between back-to-back transactions.
- Watchdog (TIMEOUT>0):
  - An 8-bit-or-wider counter increments each cycle in REQ or WAIT, saturating.
  - When the counter equals TIMEOUT-1 and no handshake or response occurs that cycle: set timeout_err, capture data 0, go to RESP. The owner still receives exactly one resp_valid.
  - A response arriving in the same cycle as expiry wins: the data is delivered and timeout_err is not set.
  - timeout_err clears only on reset.
- Starvation: the IFU is never granted while lsu_req_valid is held high. This is acceptable because the core issues at most one LSU access per instruction.

Test Plan:
- Reset, then IFU request addr=0x80000000, memory ready immediately, memory responds 0x00000413 one cycle after WAIT -> ifu_resp_valid single pulse with data 0x00000413 exactly 4 cycles after acceptance; lsu_resp_valid stays 0.
- Same cycle IFU addr=0x80000004 and LSU store addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF -> LSU accepted first; mem_req shows wen=1, mask 0xF; lsu_resp_valid pulses; then IFU is accepted and mem_req shows wen=0, mask 0.
- mem_req_ready held low 5 cycles -> mem_req_valid and all fields stable for 5 cycles; both ready outputs 0; busy=1.
- TIMEOUT=8, memory never responds -> timeout_err=1 after 8 REQ/WAIT cycles; owner resp_valid pulses with data 0; the next request proceeds normally with timeout_err still 1.
- Reset asserted in WAIT, then mem_resp_valid arrives -> no resp_valid on either side; state IDLE; all outputs at reset values.
- mem_resp_valid pulsed while in REQ -> ignored; the transaction completes only on a response received in WAIT.

Source files
------------

// File: rtl/ysyx_24070014_mem_arbiter.sv
// Two-requester memory arbiter. The instruction-fetch and load/store paths
// share one memory port. Only one transaction is in flight at a time. A
// watchdog retires transactions that the memory never answers.
module ysyx_24070014_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  // instruction fetch requester (read-only)
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_data,
  // load/store requester
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_data,
  // memory side
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  // status
  output logic                busy,
  output logic                timeout_err
);

  localparam int MASK_W = DATA_W / 8;
  // Counter is at least 8 bits wide and always wide enough to reach TIMEOUT.
  localparam int CNT_W  = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // owner encoding: 0 = instruction fetch, 1 = load/store
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                expire;

  // Watchdog expiry. A ">=" compare (not "==") also covers the case where the
  // REQ handshake lands exactly on the last cycle, so a WAIT that follows it
  // still retires on its next silent cycle instead of never expiring.
  assign expire = (TIMEOUT != 0) && (cnt_q >= TO_LAST);

  // Grants are only offered while idle; the load/store path has fixed priority.
  assign lsu_req_ready = (state_q == S_IDLE) & lsu_req_valid;
  assign ifu_req_ready = (state_q == S_IDLE) & ifu_req_valid & ~lsu_req_valid;

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;

  assign ifu_resp_valid = (state_q == S_RESP) & ~owner_q;
  assign lsu_resp_valid = (state_q == S_RESP) &  owner_q;
  assign ifu_resp_data  = rdata_q;
  assign lsu_resp_data  = rdata_q;

  assign busy        = (state_q != S_IDLE);
  assign timeout_err = err_q;

  // Next-state logic: arbitration, memory handshake, response capture, watchdog.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    owner_d = owner_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    // Saturating cycle count while the memory owns the transaction.
    if ((state_q == S_REQ || state_q == S_WAIT) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (lsu_req_valid) begin
          addr_d  = lsu_req_addr;
          wen_d   = lsu_req_wen;
          wdata_d = lsu_req_wdata;
          wmask_d = lsu_req_wmask;
          owner_d = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end else if (ifu_req_valid) begin
          addr_d  = ifu_req_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          owner_d = 1'b0;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
        end else if (expire) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_WAIT: begin
        // A response on the expiry cycle wins over the watchdog.
        if (mem_resp_valid) begin
          rdata_d = mem_resp_data;
          state_d = S_RESP;
        end else if (expire) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset drops any
  // in-flight transaction without a response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      owner_q <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24070014_mem_arbiter.sv
// Directed testbench for the two-requester memory arbiter (watchdog at 8 cycles).
module tb_ysyx_24070014_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_req_addr, ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
  logic [3:0]  lsu_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
  logic [3:0]  mem_req_wmask;
  logic        busy, timeout_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_24070014_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifu_req_valid = 0; ifu_req_addr = 0;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
    checks++; if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b/%b want 0/0", ifu_resp_valid, lsu_resp_valid); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    checks++; if (mem_req_addr !== 32'h0 || mem_req_wdata !== 32'h0 || mem_req_wmask !== 4'h0 || mem_req_wen !== 1'b0) begin errors++; $display("FAIL reset_fields: addr %h wdata %h mask %h wen %b want all 0", mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen); end
    checks++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b/%b want 0/0", ifu_req_ready, lsu_req_ready); end
    checks++; if (ifu_resp_data !== 32'h0 || lsu_resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h/%h want 0/0", ifu_resp_data, lsu_resp_data); end
    reset = 1'b0;
    tick();
    $display("txn reset: done");
  endtask

  task automatic test_ifu_fetch();
    // cycle 0: accept
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000; mem_req_ready = 1;
    #1;
    checks++; if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin errors++; $display("FAIL fetch_grant: ifu/lsu ready %b/%b want 1/0", ifu_req_ready, lsu_req_ready); end
    tick(); // cycle 1: REQ
    ifu_req_valid = 0;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000 || mem_req_wen !== 1'b0 || mem_req_wmask !== 4'h0) begin errors++; $display("FAIL fetch_req: valid %b addr %h wen %b mask %h want 1 80000000 0 0", mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fetch_busy: got %b want 1", busy); end
    tick(); // cycle 2: WAIT
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL fetch_wait_valid: got %b want 0", mem_req_valid); end
    tick(); // cycle 3: memory answers
    mem_resp_valid = 1; mem_resp_data = 32'h0000_0413;
    checks++; if (ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL fetch_early_resp: got %b want 0", ifu_resp_valid); end
    tick(); // cycle 4: RESP
    mem_resp_valid = 0;
    checks++; if (ifu_resp_valid !== 1'b1 || ifu_resp_data !== 32'h0000_0413) begin errors++; $display("FAIL fetch_resp: valid %b data %h want 1 00000413", ifu_resp_valid, ifu_resp_data); end
    checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL fetch_lsu_quiet: got %b want 0", lsu_resp_valid); end
    tick(); // cycle 5: IDLE
    checks++; if (ifu_resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fetch_pulse_end: valid %b busy %b want 0 0", ifu_resp_valid, busy); end
    checks++; if (ifu_resp_data !== 32'h0000_0413) begin errors++; $display("FAIL fetch_data_hold: got %h want 00000413", ifu_resp_data); end
    $display("txn ifu_fetch: addr=80000000 data=%h", ifu_resp_data);
  endtask

  task automatic test_priority();
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF; mem_req_ready = 1;
    #1;
    checks++; if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin errors++; $display("FAIL prio_grant: lsu/ifu ready %b/%b want 1/0", lsu_req_ready, ifu_req_ready); end
    tick(); // REQ for store
    lsu_req_valid = 0;
    #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_1000 || mem_req_wen !== 1'b1 || mem_req_wmask !== 4'hF || mem_req_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL prio_store_req: valid %b addr %h wen %b mask %h wdata %h", mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata); end
    checks++; if (ifu_req_ready !== 1'b0) begin errors++; $display("FAIL prio_ready_req: got %b want 0", ifu_req_ready); end
    tick(); // WAIT
    mem_resp_valid = 1; mem_resp_data = 32'h0;
    tick(); // RESP
    mem_resp_valid = 0;
    checks++; if (lsu_resp_valid !== 1'b1 || ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL prio_store_resp: lsu/ifu valid %b/%b want 1/0", lsu_resp_valid, ifu_resp_valid); end
    checks++; if (ifu_req_ready !== 1'b0) begin errors++; $display("FAIL prio_ready_resp: got %b want 0", ifu_req_ready); end
    tick(); // IDLE: IFU granted now
    checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL prio_ifu_grant: got %b want 1", ifu_req_ready); end
    tick(); // REQ for fetch
    ifu_req_valid = 0;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0004 || mem_req_wen !== 1'b0 || mem_req_wmask !== 4'h0) begin errors++; $display("FAIL prio_fetch_req: valid %b addr %h wen %b mask %h", mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask); end
    tick(); // WAIT
    mem_resp_valid = 1; mem_resp_data = 32'h1234_5678;
    tick(); // RESP
    mem_resp_valid = 0;
    checks++; if (ifu_resp_valid !== 1'b1 || ifu_resp_data !== 32'h1234_5678 || lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL prio_fetch_resp: ifu %b data %h lsu %b", ifu_resp_valid, ifu_resp_data, lsu_resp_valid); end
    tick();
    $display("txn priority: store then fetch data=%h", ifu_resp_data);
  endtask

  task automatic test_stall();
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_2000; lsu_req_wen = 0;
    lsu_req_wdata = 32'h1111_1111; lsu_req_wmask = 4'h3; mem_req_ready = 0;
    tick(); // REQ, memory not ready
    // new requests pending must not disturb latched fields
    lsu_req_addr = 32'h9999_0000; lsu_req_wdata = 32'h2222_2222; lsu_req_wmask = 4'hC;
    ifu_req_valid = 1; ifu_req_addr = 32'h8888_0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_2000 || mem_req_wen !== 1'b0 || mem_req_wmask !== 4'h3 || mem_req_wdata !== 32'h1111_1111) begin errors++; $display("FAIL stall_hold[%0d]: valid %b addr %h wen %b mask %h wdata %h", i, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata); end
      checks++; if (lsu_req_ready !== 1'b0 || ifu_req_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stall_ready[%0d]: lsu %b ifu %b busy %b want 0 0 1", i, lsu_req_ready, ifu_req_ready, busy); end
      tick();
    end
    lsu_req_valid = 0; ifu_req_valid = 0; mem_req_ready = 1;
    tick(); // WAIT
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'hCAFE_F00D;
    tick(); // RESP
    mem_resp_valid = 0;
    checks++; if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 32'hCAFE_F00D || timeout_err !== 1'b0) begin errors++; $display("FAIL stall_resp: valid %b data %h err %b", lsu_resp_valid, lsu_resp_data, timeout_err); end
    tick();
    $display("txn stall: load data=%h", lsu_resp_data);
  endtask

  task automatic test_resp_at_expiry();
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_2004; lsu_req_wen = 0; lsu_req_wmask = 4'h0; mem_req_ready = 1;
    tick(); // REQ, count 0
    lsu_req_valid = 0;
    tick(); // WAIT, count 1
    mem_req_ready = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); // WAIT, counts 2..7
      checks++; if (busy !== 1'b1 || lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL expiry_wait[%0d]: busy %b resp %b want 1 0", i, busy, lsu_resp_valid); end
    end
    mem_resp_valid = 1; mem_resp_data = 32'h0BAD_C0DE;
    tick(); // RESP
    mem_resp_valid = 0;
    checks++; if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 32'h0BAD_C0DE || timeout_err !== 1'b0) begin errors++; $display("FAIL expiry_resp_wins: valid %b data %h err %b want 1 0badc0de 0", lsu_resp_valid, lsu_resp_data, timeout_err); end
    tick();
    $display("txn resp_at_expiry: data=%h err=%b", lsu_resp_data, timeout_err);
  endtask

  task automatic test_resp_in_req();
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_4000; lsu_req_wen = 0; mem_req_ready = 0;
    tick(); // REQ
    lsu_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'hBAD0_BAD0;
    tick(); // still REQ, stray response ignored
    mem_resp_valid = 0;
    checks++; if (mem_req_valid !== 1'b1 || lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL stray_req: mem valid %b resp %b want 1 0", mem_req_valid, lsu_resp_valid); end
    mem_req_ready = 1;
    tick(); // WAIT
    mem_req_ready = 0;
    checks++; if (mem_req_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL stray_wait: mem valid %b resp %b want 0 0", mem_req_valid, lsu_resp_valid); end
    tick(); // WAIT
    checks++; if (busy !== 1'b1 || lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL stray_still_wait: busy %b resp %b want 1 0", busy, lsu_resp_valid); end
    mem_resp_valid = 1; mem_resp_data = 32'h600D_F00D;
    tick(); // RESP
    mem_resp_valid = 0;
    checks++; if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 32'h600D_F00D) begin errors++; $display("FAIL stray_resp: valid %b data %h want 1 600df00d", lsu_resp_valid, lsu_resp_data); end
    tick();
    $display("txn resp_in_req: data=%h", lsu_resp_data);
  endtask

  task automatic test_timeout();
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0010; mem_req_ready = 0;
    tick(); // REQ, count 0
    ifu_req_valid = 0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (mem_req_valid !== 1'b1 || ifu_resp_valid !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_pending[%0d]: mem valid %b resp %b err %b want 1 0 0", i, mem_req_valid, ifu_resp_valid, timeout_err); end
      tick();
    end
    checks++; if (ifu_resp_valid !== 1'b1 || ifu_resp_data !== 32'h0 || timeout_err !== 1'b1 || lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL timeout_retire: ifu %b data %h err %b lsu %b want 1 0 1 0", ifu_resp_valid, ifu_resp_data, timeout_err, lsu_resp_valid); end
    tick();
    checks++; if (ifu_resp_valid !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_after: resp %b busy %b err %b want 0 0 1", ifu_resp_valid, busy, timeout_err); end
    // next transaction proceeds normally
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_3000; lsu_req_wen = 1;
    lsu_req_wdata = 32'h55AA_55AA; lsu_req_wmask = 4'h5; mem_req_ready = 1;
    tick(); // REQ
    lsu_req_valid = 0;
    checks++; if (mem_req_addr !== 32'h8000_3000 || mem_req_wen !== 1'b1 || mem_req_wmask !== 4'h5 || mem_req_wdata !== 32'h55AA_55AA) begin errors++; $display("FAIL timeout_next_req: addr %h wen %b mask %h wdata %h", mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata); end
    tick(); // WAIT
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h0000_0077;
    tick(); // RESP
    mem_resp_valid = 0;
    checks++; if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 32'h0000_0077 || timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_next_resp: valid %b data %h err %b want 1 77 1", lsu_resp_valid, lsu_resp_data, timeout_err); end
    tick();
    $display("txn timeout: err=%b", timeout_err);
  endtask

  task automatic test_reset_in_wait();
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_5000; lsu_req_wen = 1;
    lsu_req_wdata = 32'hA5A5_A5A5; lsu_req_wmask = 4'hF; mem_req_ready = 1;
    tick(); // REQ
    lsu_req_valid = 0;
    tick(); // WAIT
    mem_req_ready = 0; reset = 1;
    tick(); // reset taken
    reset = 0; mem_resp_valid = 1; mem_resp_data = 32'h0000_0099;
    tick();
    mem_resp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || busy !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_quiet[%0d]: ifu %b lsu %b busy %b memv %b want 0", i, ifu_resp_valid, lsu_resp_valid, busy, mem_req_valid); end
      checks++; if (timeout_err !== 1'b0 || mem_req_addr !== 32'h0 || mem_req_wdata !== 32'h0 || mem_req_wmask !== 4'h0 || mem_req_wen !== 1'b0 || lsu_resp_data !== 32'h0) begin errors++; $display("FAIL rst_wait_values[%0d]: err %b addr %h wdata %h mask %h wen %b data %h", i, timeout_err, mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen, lsu_resp_data); end
      tick();
    end
    $display("txn reset_in_wait: dropped");
  endtask

  initial begin
    test_reset();
    test_ifu_fetch();
    test_priority();
    test_stall();
    test_resp_at_expiry();
    test_resp_in_req();
    test_timeout();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

endmodule
